// File: rtl/alu_seq.sv
// Command sequencer and result register stage wrapped around the 8-bit ALU.
// Runs (cmd_iter+1) ALU passes, feeding each Y back as A, then holds the result.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | ready for a command; operands captured on cmd_vld
//   ST_RUN  | one ALU pass per cycle, cnt counts down to zero
//   ST_DONE | result presented on rslt, waiting for rslt_rdy
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [WIDTH-1:0]  cmd_A,
    input  logic [WIDTH-1:0]  cmd_B,
    input  logic [1:0]        cmd_mode,
    input  logic [ITER_W-1:0] cmd_iter,

    output logic [WIDTH-1:0]  alu_A,
    output logic [WIDTH-1:0]  alu_B,
    output logic [1:0]        alu_mode,
    input  logic [WIDTH-1:0]  alu_Y,

    output logic [WIDTH-1:0]  rslt,
    output logic              rslt_vld,
    input  logic              rslt_rdy,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    acc_q;
    logic [WIDTH-1:0]    b_q;
    logic [1:0]          mode_q;
    logic [ITER_W-1:0]   cnt_q;
    logic [WIDTH-1:0]    rslt_q;
    logic                cnt_tc;

    // Terminal count: the pass running now is the last one.
    assign cnt_tc = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rslt_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            b_q    <= '0;
            mode_q <= '0;
            cnt_q  <= '0;
            rslt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        acc_q  <= cmd_A;
                        b_q    <= cmd_B;
                        mode_q <= cmd_mode;
                        cnt_q  <= cmd_iter;
                    end
                end
                ST_RUN: begin
                    acc_q <= alu_Y;
                    if (cnt_tc) begin
                        rslt_q <= alu_Y;
                    end else begin
                        cnt_q <= cnt_q - ITER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs decode from state only, so no input reaches an output combinationally.
    assign cmd_rdy  = (state_q == ST_IDLE);
    assign rslt_vld = (state_q == ST_DONE);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);

    assign alu_A    = acc_q;
    assign alu_B    = b_q;
    assign alu_mode = mode_q;
    assign rslt     = rslt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with the combinational ALU closed around it.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [7:0] cmd_A;
    logic [7:0] cmd_B;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_iter;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [1:0] alu_mode;
    logic [7:0] alu_Y;
    logic [7:0] rslt;
    logic       rslt_vld;
    logic       rslt_rdy;
    logic       busy;

    int n_chk;
    int n_pass;

    alu_seq #(.WIDTH(8), .ITER_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_A    (cmd_A),
        .cmd_B    (cmd_B),
        .cmd_mode (cmd_mode),
        .cmd_iter (cmd_iter),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_mode (alu_mode),
        .alu_Y    (alu_Y),
        .rslt     (rslt),
        .rslt_vld (rslt_vld),
        .rslt_rdy (rslt_rdy),
        .busy     (busy)
    );

    // The ALU the sequencer drives: 00 A/2+B, 01 A-B, 10 A>>1, 11 A<<1.
    always_comb begin
        alu_Y = '0;
        case (alu_mode)
            2'b00:   alu_Y = (alu_A >> 1) + alu_B;
            2'b01:   alu_Y = alu_A - alu_B;
            2'b10:   alu_Y = alu_A >> 1;
            default: alu_Y = alu_A << 1;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] m, input logic [3:0] it);
        @(negedge clk);
        chk("cmd_rdy_before_send", int'(cmd_rdy), 1);
        cmd_A    = a;
        cmd_B    = b;
        cmd_mode = m;
        cmd_iter = it;
        cmd_vld  = 1'b1;
        @(posedge clk);
        #1 cmd_vld = 1'b0;
    endtask

    // Returns the number of edges after acceptance until rslt_vld is seen.
    task automatic wait_rslt(output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rslt_vld) begin
                found = 1'b1;
                break;
            end
            lat++;
        end
        if (!found) chk("rslt_vld_timeout", 0, 1);
    endtask

    task automatic handshake(input int exp_rslt);
        @(negedge clk);
        rslt_rdy = 1'b1;
        @(posedge clk);
        #1 rslt_rdy = 1'b0;
        @(negedge clk);
        chk("vld_after_hs", int'(rslt_vld), 0);
        chk("rdy_after_hs", int'(cmd_rdy), 1);
        chk("rslt_kept_after_hs", int'(rslt), exp_rslt);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] m, input logic [3:0] it,
                           input int exp_rslt, input int exp_lat);
        int lat;
        send(a, b, m, it);
        wait_rslt(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rslt"}, int'(rslt), exp_rslt);
        handshake(exp_rslt);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        cmd_A    = '0;
        cmd_B    = '0;
        cmd_mode = '0;
        cmd_iter = '0;
        rslt_rdy = 1'b0;

        #3;
        chk("rst_cmd_rdy", int'(cmd_rdy), 1);
        chk("rst_rslt_vld", int'(rslt_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rslt", int'(rslt), 0);
        chk("rst_alu_A", int'(alu_A), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Subtract over three passes, tracing what the ALU sees.
        send(8'd100, 8'd7, 2'b01, 4'd2);
        @(negedge clk);
        chk("sub_alu_A0", int'(alu_A), 100);
        chk("sub_alu_B", int'(alu_B), 7);
        chk("sub_alu_mode", int'(alu_mode), 1);
        chk("sub_busy", int'(busy), 1);
        chk("sub_cmd_rdy", int'(cmd_rdy), 0);
        chk("sub_vld0", int'(rslt_vld), 0);
        @(negedge clk);
        chk("sub_alu_A1", int'(alu_A), 93);
        chk("sub_vld1", int'(rslt_vld), 0);
        @(negedge clk);
        chk("sub_alu_A2", int'(alu_A), 86);
        chk("sub_vld2", int'(rslt_vld), 0);
        @(negedge clk);
        chk("sub_vld3", int'(rslt_vld), 1);
        chk("sub_rslt", int'(rslt), 'h4F);
        handshake('h4F);

        // Shift left with wrap-out, single pass and four passes.
        run_cmd("shl1", 8'h81, 8'h00, 2'b11, 4'd0, 'h02, 1);
        run_cmd("shl4", 8'h01, 8'h00, 2'b11, 4'd3, 'h10, 4);

        // Halve-add then hold off the consumer for five cycles.
        begin
            int lat;
            send(8'h40, 8'h10, 2'b00, 4'd1);
            wait_rslt(lat);
            chk("hadd_lat", lat, 2);
            chk("hadd_rslt", int'(rslt), 'h28);
            for (int i = 0; i < 5; i++) begin
                cmd_vld  = (i == 1);
                cmd_A    = 8'hFF;
                cmd_iter = 4'd0;
                @(negedge clk);
                chk("bp_vld", int'(rslt_vld), 1);
                chk("bp_rslt", int'(rslt), 'h28);
                chk("bp_cmd_rdy", int'(cmd_rdy), 0);
            end
            cmd_vld = 1'b0;
            chk("bp_alu_A_held", int'(alu_A), 'h28);
            handshake('h28);
            chk("bp_not_queued", int'(alu_A), 'h28);
        end

        // Maximum pass count: 16 passes of 200-3.
        run_cmd("max_iter", 8'd200, 8'd3, 2'b01, 4'd15, 'h98, 16);

        // Underflow wrap, then a second command held on cmd_vld with rslt_rdy tied high.
        @(negedge clk);
        rslt_rdy = 1'b1;
        cmd_A    = 8'd5;
        cmd_B    = 8'd7;
        cmd_mode = 2'b01;
        cmd_iter = 4'd0;
        cmd_vld  = 1'b1;
        @(negedge clk);
        chk("b2b_busy0", int'(busy), 1);
        chk("b2b_vld0", int'(rslt_vld), 0);
        cmd_A    = 8'h30;
        cmd_B    = 8'h00;
        cmd_mode = 2'b10;
        @(negedge clk);
        chk("b2b_vld1", int'(rslt_vld), 1);
        chk("b2b_rslt1", int'(rslt), 'hFE);
        chk("b2b_rdy1", int'(cmd_rdy), 0);
        @(negedge clk);
        chk("b2b_vld_one_cycle", int'(rslt_vld), 0);
        chk("b2b_rdy_idle", int'(cmd_rdy), 1);
        chk("b2b_rslt_kept", int'(rslt), 'hFE);
        @(negedge clk);
        chk("b2b_second_accept", int'(busy), 1);
        chk("b2b_second_A", int'(alu_A), 'h30);
        cmd_vld = 1'b0;
        @(negedge clk);
        chk("b2b_vld2", int'(rslt_vld), 1);
        chk("b2b_rslt2", int'(rslt), 'h18);
        @(negedge clk);
        chk("b2b_vld2_drop", int'(rslt_vld), 0);
        rslt_rdy = 1'b0;

        // Asynchronous reset in the middle of a long run.
        send(8'h55, 8'h01, 2'b01, 4'd15);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_cmd_rdy", int'(cmd_rdy), 1);
        chk("arst_rslt_vld", int'(rslt_vld), 0);
        chk("arst_alu_A", int'(alu_A), 0);
        chk("arst_alu_B", int'(alu_B), 0);
        chk("arst_alu_mode", int'(alu_mode), 0);
        chk("arst_rslt", int'(rslt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rdy", int'(cmd_rdy), 1);
        chk("post_rst_vld", int'(rslt_vld), 0);

        run_cmd("post_rst_cmd", 8'd5, 8'd7, 2'b01, 4'd0, 'hFE, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
